// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets a TinyRV1 core's instruction-fetch port (imem) and
// data port (dmem) share one single-ported memory. Only one transaction may be
// outstanding at a time. dmem normally has priority, but after MAX_D_STREAK
// consecutive dmem grants taken while imem was waiting, imem wins the next one.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          imemreq_val,
  output logic          imemreq_rdy,
  input  logic [AW-1:0] imemreq_addr,
  output logic          imemresp_val,
  output logic [DW-1:0] imemresp_data,

  input  logic          dmemreq_val,
  output logic          dmemreq_rdy,
  input  logic          dmemreq_type,
  input  logic [AW-1:0] dmemreq_addr,
  input  logic [DW-1:0] dmemreq_wdata,
  output logic          dmemresp_val,
  output logic [DW-1:0] dmemresp_rdata,

  output logic          memreq_val,
  input  logic          memreq_rdy,
  output logic          memreq_type,
  output logic [AW-1:0] memreq_addr,
  output logic [DW-1:0] memreq_wdata,
  input  logic          memresp_val,
  input  logic [DW-1:0] memresp_data,

  output logic          busy
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_D_STREAK);

  state_t     r_state;
  logic       r_owner;   // 0 = imem, 1 = dmem
  logic [3:0] r_streak;  // dmem grants in a row taken while imem was waiting

  logic w_idle;
  logic w_wait;
  logic w_dwin;
  logic w_iwin;
  logic w_fire;

  // Same-cycle arbitration, request muxing and response routing; reset gates every handshake output.
  always_comb begin
    w_idle = rst && (r_state == ST_IDLE);
    w_wait = rst && (r_state == ST_WAIT);

    w_dwin = dmemreq_val && (!imemreq_val || (r_streak < LP_MAX));
    w_iwin = imemreq_val && !w_dwin;

    memreq_val   = w_idle && (w_dwin || w_iwin);
    memreq_type  = w_dwin && dmemreq_type;
    memreq_addr  = w_dwin ? dmemreq_addr  : imemreq_addr;
    memreq_wdata = w_dwin ? dmemreq_wdata : '0;

    imemreq_rdy  = w_idle && w_iwin && memreq_rdy;
    dmemreq_rdy  = w_idle && w_dwin && memreq_rdy;
    w_fire       = memreq_val && memreq_rdy;

    busy         = w_wait;

    // A response seen in IDLE is spurious and is never forwarded.
    imemresp_val   = w_wait && memresp_val && !r_owner;
    dmemresp_val   = w_wait && memresp_val &&  r_owner;
    imemresp_data  = memresp_data;
    dmemresp_rdata = memresp_data;
  end

  // Transaction state, owner of the outstanding request and the anti-starvation streak.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= 1'b0;
      r_streak <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_state <= ST_WAIT;
            r_owner <= w_dwin;
            if (w_dwin && imemreq_val) begin
              r_streak <= (r_streak >= LP_MAX) ? LP_MAX : r_streak + 4'd1;
            end else begin
              r_streak <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (memresp_val) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic from both requesters against a random-latency memory.
module tb_mem_port_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imemreq_val, imemreq_rdy;
  logic [AW-1:0] imemreq_addr;
  logic          imemresp_val;
  logic [DW-1:0] imemresp_data;
  logic          dmemreq_val, dmemreq_rdy, dmemreq_type;
  logic [AW-1:0] dmemreq_addr;
  logic [DW-1:0] dmemreq_wdata;
  logic          dmemresp_val;
  logic [DW-1:0] dmemresp_rdata;
  logic          memreq_val, memreq_rdy, memreq_type;
  logic [AW-1:0] memreq_addr;
  logic [DW-1:0] memreq_wdata;
  logic          memresp_val;
  logic [DW-1:0] memresp_data;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_D_STREAK(MAXS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(dmemresp_val), .dmemresp_rdata(dmemresp_rdata),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data),
    .busy(busy)
  );

  typedef struct {
    bit          wr;
    logic [31:0] data;
  } exp_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem  [logic [31:0]];  // reference view of memory contents
  logic [31:0] phys_mem [logic [31:0]];  // the memory model's own storage
  exp_t        iq [$];
  exp_t        dq [$];
  bit          gseq [$];                 // 1 = dmem granted, 0 = imem granted
  int unsigned mdl_streak = 0;
  bit          i_done = 0;
  bit          d_done = 0;
  logic [31:0] p_data;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] phys_rd(logic [31:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_val(a);
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic note_fail(string name, string msg);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    imemreq_val   = 1'b0;
    imemreq_addr  = '0;
    dmemreq_val   = 1'b0;
    dmemreq_type  = 1'b0;
    dmemreq_addr  = '0;
    dmemreq_wdata = '0;
    memreq_rdy    = 1'b0;
    memresp_val   = 1'b0;
    memresp_data  = '0;
  endtask

  // Memory side of an accepted request: store writes, look up read data.
  task automatic accept_mem();
    if (memreq_type) begin
      phys_mem[memreq_addr] = memreq_wdata;
      p_data = $urandom;
    end else begin
      p_data = phys_rd(memreq_addr);
    end
  endtask

  task automatic do_reset();
    step();
    clr_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Reference model: decides each grant from the arbitration rules and queues the expected response.
  task automatic monitor();
    exp_t e;
    bit   exp_d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        iq.delete();
        dq.delete();
        mdl_streak = 0;
      end else begin
        if (imemresp_val && dmemresp_val)
          note_fail("dual_resp", "both response valids high together");
        if (imemresp_val) begin
          if (iq.size() == 0) note_fail("imem_resp_unexpected", "imemresp_val with nothing outstanding");
          else begin
            e = iq.pop_front();
            chk("imem_rdata", imemresp_data, e.data);
          end
        end
        if (dmemresp_val) begin
          if (dq.size() == 0) note_fail("dmem_resp_unexpected", "dmemresp_val with nothing outstanding");
          else begin
            e = dq.pop_front();
            if (!e.wr) chk("dmem_rdata", dmemresp_rdata, e.data);
          end
        end
        if (memreq_val && memreq_rdy) begin
          if (!imemreq_val && !dmemreq_val)
            note_fail("req_no_source", "memreq fired with no requester valid");
          exp_d = dmemreq_val && (!imemreq_val || (mdl_streak < MAXS));
          chk("grant_dmem", dmemreq_rdy, exp_d);
          chk("grant_imem", imemreq_rdy, !exp_d);
          gseq.push_back(dmemreq_rdy);
          if (exp_d) begin
            chk("req_addr_d", memreq_addr, dmemreq_addr);
            chk("req_type_d", memreq_type, dmemreq_type);
            if (dmemreq_type) begin
              chk("req_wdata", memreq_wdata, dmemreq_wdata);
              ref_mem[dmemreq_addr] = dmemreq_wdata;
              e.wr = 1'b1;
              e.data = '0;
            end else begin
              e.wr = 1'b0;
              e.data = ref_rd(dmemreq_addr);
            end
            dq.push_back(e);
            if (imemreq_val) mdl_streak = (mdl_streak < MAXS) ? mdl_streak + 1 : MAXS;
            else             mdl_streak = 0;
          end else begin
            chk("req_addr_i", memreq_addr, imemreq_addr);
            chk("req_type_i", memreq_type, 1'b0);
            e.wr = 1'b0;
            e.data = ref_rd(imemreq_addr);
            iq.push_back(e);
            mdl_streak = 0;
          end
        end
      end
    end
  endtask

  task automatic imem_drv(int unsigned n);
    int unsigned t;
    for (int unsigned k = 0; k < n; k++) begin
      step();
      imemreq_val = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
      t = 0;
      forever begin
        @(negedge clk);
        if (imemreq_rdy) break;
        t++;
        if (t > 300) begin
          note_fail("imem_rdy_timeout", "imem request not accepted within 300 cycles");
          break;
        end
        step();
      end
    end
    step();
    imemreq_val = 1'b0;
    i_done = 1'b1;
  endtask

  task automatic dmem_drv(int unsigned n);
    int unsigned t;
    for (int unsigned k = 0; k < n; k++) begin
      step();
      dmemreq_val = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      dmemreq_val   = 1'b1;
      dmemreq_type  = 1'($urandom_range(0, 1));
      dmemreq_addr  = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
      dmemreq_wdata = $urandom;
      t = 0;
      forever begin
        @(negedge clk);
        if (dmemreq_rdy) break;
        t++;
        if (t > 300) begin
          note_fail("dmem_rdy_timeout", "dmem request not accepted within 300 cycles");
          break;
        end
        step();
      end
    end
    step();
    dmemreq_val = 1'b0;
    d_done = 1'b1;
  endtask

  // Random-latency memory with random backpressure and occasional spurious responses while idle.
  task automatic mem_model();
    bit          pend = 1'b0;
    int unsigned cnt = 0;
    int unsigned cyc = 0;
    logic [31:0] pd = '0;
    while (!(i_done && d_done && !pend) && cyc < 20000) begin
      cyc++;
      step();
      memresp_val = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          memresp_val  = 1'b1;
          memresp_data = pd;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        memresp_val  = 1'b1;
        memresp_data = $urandom;
      end
      memreq_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (memreq_val && memreq_rdy) begin
        accept_mem();
        pd   = p_data;
        pend = 1'b1;
        cnt  = $urandom_range(1, 3);
      end
    end
    if (cyc >= 20000) note_fail("rand_phase_timeout", "random phase did not drain");
    step();
    memresp_val = 1'b0;
    memreq_rdy  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit exp_pat [10];
    exp_pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    clr_inputs();
    fork
      monitor();
    join_none

    // Reset with every input high, then idle
    step();
    rst = 1'b0;
    imemreq_val = 1'b1; dmemreq_val = 1'b1; dmemreq_type = 1'b1;
    memreq_rdy = 1'b1; memresp_val = 1'b1;
    imemreq_addr = '1; dmemreq_addr = '1; dmemreq_wdata = '1;
    @(negedge clk);
    chk("rst_memreq_val", memreq_val, 1'b0);
    chk("rst_imemreq_rdy", imemreq_rdy, 1'b0);
    chk("rst_dmemreq_rdy", dmemreq_rdy, 1'b0);
    chk("rst_imemresp_val", imemresp_val, 1'b0);
    chk("rst_dmemresp_val", dmemresp_val, 1'b0);
    chk("rst_busy", busy, 1'b0);
    step();
    clr_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("idle_memreq_val", memreq_val, 1'b0);
    step();
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Single imem read, response two cycles after acceptance
    ref_mem[32'h100]  = 32'hDEADBEEF;
    phys_mem[32'h100] = 32'hDEADBEEF;
    step();
    imemreq_val = 1'b1; imemreq_addr = 32'h100; memreq_rdy = 1'b1;
    @(negedge clk);
    chk("t2_memreq_val", memreq_val, 1'b1);
    chk("t2_memreq_addr", memreq_addr, 32'h100);
    chk("t2_imemreq_rdy", imemreq_rdy, 1'b1);
    accept_mem();
    step();
    imemreq_val = 1'b0;
    @(negedge clk);
    chk("t2_busy_c1", busy, 1'b1);
    chk("t2_iresp_c1", imemresp_val, 1'b0);
    chk("t2_dresp_c1", dmemresp_val, 1'b0);
    step();
    memresp_val = 1'b1; memresp_data = p_data;
    @(negedge clk);
    chk("t2_busy_c2", busy, 1'b1);
    chk("t2_iresp_c2", imemresp_val, 1'b1);
    chk("t2_idata", imemresp_data, 32'hDEADBEEF);
    chk("t2_dresp_c2", dmemresp_val, 1'b0);
    step();
    memresp_val = 1'b0;
    @(negedge clk);
    chk("t2_busy_c3", busy, 1'b0);

    // Continuous contention with one-cycle memory latency
    do_reset();
    gseq.delete();
    for (int k = 0; k < 10; k++) begin
      step();
      memresp_val = 1'b0;
      imemreq_val = 1'b1; imemreq_addr = 32'h300;
      dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h400 + 32'(k) * 32'd4;
      memreq_rdy = 1'b1;
      @(negedge clk);
      if (memreq_val && memreq_rdy) accept_mem();
      else note_fail("t3_no_fire", "no request issued under contention");
      step();
      memresp_val = 1'b1; memresp_data = p_data;
      @(negedge clk);
    end
    step();
    clr_inputs();
    chk("t3_grant_count", gseq.size(), 10);
    for (int k = 0; k < 10 && k < gseq.size(); k++)
      chk($sformatf("t3_grant_%0d", k), gseq[k], exp_pat[k]);

    // Backpressure on a dmem write
    step();
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h40; dmemreq_wdata = 32'h55;
    memreq_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_memreq_val", memreq_val, 1'b1);
      chk("t4_memreq_addr", memreq_addr, 32'h40);
      chk("t4_memreq_wdata", memreq_wdata, 32'h55);
      chk("t4_memreq_type", memreq_type, 1'b1);
      chk("t4_dmemreq_rdy_low", dmemreq_rdy, 1'b0);
      step();
    end
    memreq_rdy = 1'b1;
    @(negedge clk);
    chk("t4_dmemreq_rdy_fire", dmemreq_rdy, 1'b1);
    accept_mem();
    step();
    dmemreq_val = 1'b0; memreq_rdy = 1'b0;
    @(negedge clk);
    chk("t4_busy", busy, 1'b1);
    step();
    memresp_val = 1'b1; memresp_data = p_data;
    @(negedge clk);
    chk("t4_dresp", dmemresp_val, 1'b1);
    chk("t4_iresp", imemresp_val, 1'b0);
    step();
    memresp_val = 1'b0;

    // Reset while a transaction is outstanding; the late response must be dropped
    imemreq_val = 1'b1; imemreq_addr = 32'h200; memreq_rdy = 1'b1;
    @(negedge clk);
    chk("t5_imemreq_rdy", imemreq_rdy, 1'b1);
    accept_mem();
    step();
    imemreq_val = 1'b0;
    @(negedge clk);
    chk("t5_busy_wait", busy, 1'b1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy_in_rst", busy, 1'b0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_after_rst", busy, 1'b0);
    step();
    memresp_val = 1'b1; memresp_data = p_data;
    @(negedge clk);
    chk("t5_late_iresp", imemresp_val, 1'b0);
    chk("t5_late_dresp", dmemresp_val, 1'b0);
    chk("t5_late_busy", busy, 1'b0);
    step();
    memresp_val = 1'b0;
    imemreq_val = 1'b1; imemreq_addr = 32'h204; memreq_rdy = 1'b1;
    @(negedge clk);
    chk("t5_next_rdy", imemreq_rdy, 1'b1);
    accept_mem();
    step();
    imemreq_val = 1'b0; memresp_val = 1'b1; memresp_data = p_data;
    @(negedge clk);
    chk("t5_next_iresp", imemresp_val, 1'b1);

    // Spurious response while idle
    step();
    memresp_val = 1'b1; memresp_data = 32'hBAD0BAD0; memreq_rdy = 1'b0;
    @(negedge clk);
    chk("t6_iresp", imemresp_val, 1'b0);
    chk("t6_dresp", dmemresp_val, 1'b0);
    chk("t6_busy", busy, 1'b0);
    step();
    memresp_val = 1'b0;
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h44; memreq_rdy = 1'b1;
    @(negedge clk);
    chk("t6_dmemreq_rdy", dmemreq_rdy, 1'b1);
    accept_mem();
    step();
    dmemreq_val = 1'b0; memresp_val = 1'b1; memresp_data = p_data;
    @(negedge clk);
    chk("t6_dresp_after", dmemresp_val, 1'b1);
    step();
    clr_inputs();

    // Randomized traffic from both ports
    fork
      imem_drv(150);
      dmem_drv(150);
      mem_model();
    join
    repeat (4) step();
    chk("end_iq_empty", iq.size(), 0);
    chk("end_dq_empty", dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the processor's instruction-fetch port (imem) and its data port (dmem) for a TinyRV1 core. It arbitrates val/rdy requests, allows one outstanding transaction, and routes the memory response back to the requester that issued it. dmem has priority, and a bounded-streak rule guarantees that fetch is never starved. It sits between the processor and the memory model.

Parameters:
MAX_D_STREAK, 4, maximum consecutive dmem grants while imem is waiting before imem must win; legal range 1..15.
AW, 32, address width.
DW, 32, data width.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; asynchronous, active-low (0 = in reset)
imemreq_val  in  1  fetch request valid
imemreq_rdy  out  1  fetch request accepted this cycle
imemreq_addr  in  AW  fetch address
imemresp_val  out  1  fetch response valid; one cycle; the requester cannot backpressure it
imemresp_data  out  DW  fetch read data
dmemreq_val  in  1  data request valid
dmemreq_rdy  out  1  data request accepted this cycle
dmemreq_type  in  1  0 = read, 1 = write
dmemreq_addr  in  AW  data address
dmemreq_wdata  in  DW  write data
dmemresp_val  out  1  data response valid; one cycle; for writes it is an acknowledge and the data is don't-care
dmemresp_rdata  out  DW  data read data
memreq_val  out  1  request valid to memory
memreq_rdy  in  1  memory accepts the request
memreq_type  out  1  0 = read, 1 = write
memreq_addr  out  AW  address to memory
memreq_wdata  out  DW  write data to memory
memresp_val  in  1  memory response valid
memresp_data  in  DW  memory response data
busy  out  1  a transaction is outstanding

Behaviour:
- State machine: IDLE, WAIT. Registers: state, owner (0 = imem, 1 = dmem), streak counter (4 bits). On rst = 0 they clear asynchronously to IDLE, owner 0 and streak 0.
- While rst = 0, every output val/rdy and busy is forced to 0. Data outputs are don't-care.
- Arbitration in IDLE is combinational, decided in the same cycle:
  - Only one requester valid: it wins.
  - Both valid and streak < MAX_D_STREAK: dmem wins.
  - Both valid and streak == MAX_D_STREAK: imem wins.
- In IDLE, the winner's payload drives memreq_* and memreq_val = 1.
  - Winner's req_rdy = memreq_rdy. Loser's req_rdy = 0.
  - No valid requester: memreq_val = 0 and both rdy = 0.
- Fire = memreq_val & memreq_rdy. On fire: owner <= winner, state <= WAIT.
- Streak update, at fire only:
  - dmem wins while imemreq_val = 1: streak += 1, saturating at MAX_D_STREAK.
  - imem wins: streak <= 0.
  - dmem wins with imemreq_val = 0: streak <= 0.
- If memreq_rdy = 0, the winner may change next cycle. Requesters hold val and payload stable until their rdy is seen; this is required of requesters, not enforced here.
- In WAIT:
  - memreq_val = 0, both req_rdy = 0, busy = 1.
  - On memresp_val: drive owner's resp_val = 1 combinationally in the same cycle, with resp data = memresp_data. The other resp_val stays 0. state <= IDLE.
  - A new request can fire the cycle after the response. There is no same-cycle response plus new request overlap.
- Memory returns its response no earlier than the cycle after acceptance. memresp_val in IDLE is spurious: it is ignored and no resp_val is asserted.
- Reset asserted mid-transaction drops the outstanding transaction. A late memory response after release lands in IDLE and is ignored.
- Throughput: at most one transaction per 2 cycles (accept cycle, then a response cycle ≥ 1 cycle later).
- Latency, requester view: resp_val arrives in the same cycle as memresp_val.

Test Plan:
1. Reset then idle: rst = 0 with every input 1 → all val/rdy and busy = 0. Release, no requests → memreq_val = 0, state stays IDLE.
2. Single imem read:
   - Stimulus: imemreq addr 0x100, memreq_rdy = 1; memory responds 2 cycles later with 0xDEADBEEF.
   - Required: memreq_addr = 0x100 and imemreq_rdy = 1 in cycle 0; busy = 1 in cycles 1–2; imemresp_val = 1 with data 0xDEADBEEF on the response cycle; dmemresp_val = 0 throughout.
3. Contention and anti-starvation with MAX_D_STREAK = 4:
   - Stimulus: imem and dmem both valid continuously, 1-cycle memory latency.
   - Required grant order: D, D, D, D, I, D, D, D, D, I.
   - Required: imem never waits more than 4 transactions.
4. Backpressure:
   - Stimulus: dmem write addr 0x40, wdata 0x55, memreq_rdy = 0 for 3 cycles.
   - Required: memreq_val = 1 with payload stable and dmemreq_rdy = 0 for 3 cycles; fire on the 4th cycle; the later response gives dmemresp_val = 1.
5. Reset mid-op: fire an imem read, assert rst in WAIT, release, then pulse memresp_val → no imemresp_val, state IDLE, next request accepted normally.
6. Spurious response: memresp_val = 1 in IDLE → both resp_val = 0, state unchanged.
